// File: rtl/bitty_pkg.sv
// rtl/bitty_pkg.sv - shared widths, constants and fetch-state encodings for the Bitty core
package bitty_pkg;

   localparam int INST_W = 16;
   localparam logic [INST_W-1:0] HALT_WORD_DEFAULT = 16'hFFFF;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_FETCH    = 3'd1,
      ST_WAIT_MEM = 3'd2,
      ST_ISSUE    = 3'd3,
      ST_EXEC     = 3'd4,
      ST_HALTED   = 3'd5
   } fetch_state_t;

endpackage

// File: rtl/bitty_pc_counter.sv
// rtl/bitty_pc_counter.sv - program counter with load-start and increment-with-wrap
module bitty_pc_counter #(
   parameter int                ADDR_W     = 8,
   parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              inc,
   output logic [ADDR_W-1:0] pc
);

   // Wrap from all-ones back to zero falls out of the ADDR_W-bit add.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc <= START_ADDR;
      end else if (load) begin
         pc <= START_ADDR;
      end else if (inc) begin
         pc <= pc + 1'b1;
      end
   end

endmodule

// File: rtl/bitty_fetch_unit.sv
// rtl/bitty_fetch_unit.sv - fetches instruction words, issues them to the core, retires and halts
module bitty_fetch_unit
   import bitty_pkg::*;
#(
   parameter int                ADDR_W     = 8,
   parameter logic [ADDR_W-1:0] START_ADDR = '0,
   parameter logic [INST_W-1:0] HALT_WORD  = HALT_WORD_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   input  logic [INST_W-1:0] mem_rd_data,
   input  logic              mem_rd_valid,
   output logic [INST_W-1:0] instruction,
   output logic              run,
   input  logic              done,
   output logic [ADDR_W-1:0] pc,
   output logic [15:0]       retired,
   output logic              halted,
   output logic              busy
);

   fetch_state_t      state;
   fetch_state_t      next_state;
   logic              pc_load;
   logic              pc_inc;
   logic              inst_load;
   logic              retire;
   logic              stop_q;
   logic [INST_W-1:0] inst_q;
   logic [15:0]       retired_cnt;

   bitty_pc_counter #(
      .ADDR_W     (ADDR_W),
      .START_ADDR (START_ADDR)
   ) u_pc (
      .clk   (clk),
      .reset (reset),
      .load  (pc_load),
      .inc   (pc_inc),
      .pc    (pc)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      pc_load    = 1'b0;
      pc_inc     = 1'b0;
      inst_load  = 1'b0;
      retire     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               pc_load    = 1'b1;
               next_state = ST_FETCH;
            end
         end
         ST_FETCH: begin
            next_state = ST_WAIT_MEM;
         end
         ST_WAIT_MEM: begin
            // A HALT word is swallowed here so the core never sees it.
            if (mem_rd_valid) begin
               if (mem_rd_data == HALT_WORD) begin
                  next_state = ST_HALTED;
               end else begin
                  inst_load  = 1'b1;
                  next_state = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            next_state = ST_EXEC;
         end
         ST_EXEC: begin
            if (done) begin
               pc_inc     = 1'b1;
               retire     = 1'b1;
               next_state = (stop || stop_q) ? ST_HALTED : ST_FETCH;
            end
         end
         ST_HALTED: begin
            if (start) begin
               pc_load    = 1'b1;
               next_state = ST_FETCH;
            end
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // Remembers a stop seen anywhere in the instruction so it takes effect at done.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stop_q <= 1'b0;
      end else if (next_state == ST_HALTED) begin
         stop_q <= 1'b0;
      end else if (busy && stop) begin
         stop_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         inst_q <= '0;
      end else if (inst_load) begin
         inst_q <= mem_rd_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         retired_cnt <= '0;
      end else if (retire && (retired_cnt != 16'hFFFF)) begin
         retired_cnt <= retired_cnt + 16'd1;
      end
   end

   assign mem_addr    = pc;
   assign mem_rd_en   = (state == ST_FETCH);
   assign run         = (state == ST_ISSUE);
   assign halted      = (state == ST_HALTED);
   assign busy        = (state != ST_IDLE) && (state != ST_HALTED);
   assign instruction = inst_q;
   assign retired     = retired_cnt;

endmodule

// File: tb/tb_bitty_fetch_unit.sv
// tb/tb_bitty_fetch_unit.sv - directed table-driven bench for bitty_fetch_unit
module tb_bitty_fetch_unit;
   import bitty_pkg::*;

   localparam int AW = 2;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic              tb_stop = 1'b0;
   logic              core_stop = 1'b0;
   logic              stop;
   logic [AW-1:0]     mem_addr;
   logic              mem_rd_en;
   logic [INST_W-1:0] mem_rd_data = '0;
   logic              mem_rd_valid = 1'b0;
   logic [INST_W-1:0] instruction;
   logic              run;
   logic              done = 1'b0;
   logic [AW-1:0]     pc;
   logic [15:0]       retired;
   logic              halted;
   logic              busy;

   assign stop = tb_stop | core_stop;

   always #5 clk = ~clk;

   bitty_fetch_unit #(
      .ADDR_W     (AW),
      .START_ADDR (2'd0),
      .HALT_WORD  (16'hFFFF)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .stop         (stop),
      .mem_addr     (mem_addr),
      .mem_rd_en    (mem_rd_en),
      .mem_rd_data  (mem_rd_data),
      .mem_rd_valid (mem_rd_valid),
      .instruction  (instruction),
      .run          (run),
      .done         (done),
      .pc           (pc),
      .retired      (retired),
      .halted       (halted),
      .busy         (busy)
   );

   logic [15:0]   mem [4];
   int            mem_lat = 1;
   int            done_lat = 3;
   bit            stop_on_done = 1'b0;

   int            cyc = 0;
   int            run_cnt = 0, fetch_cnt = 0;
   int            stable_err = 0, rden_err = 0, lat_err = 0, halt_issued = 0;
   int            valid_cyc = 0, mem_cnt = 0, core_cnt = 0;
   int            run_cyc [256];
   logic [AW-1:0] run_pc [256];
   logic [15:0]   run_inst [256];
   logic [AW-1:0] rd_addr = '0;
   bit            prev_rd_en = 1'b0, in_exec = 1'b0;
   logic [15:0]   exec_inst = '0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitors, then memory and core models, all away from the rising edge.
   always @(negedge clk) begin
      if (!reset) in_exec = 1'b0;
      if (run) begin
         if (cyc != valid_cyc + 1) lat_err++;
         if (instruction == 16'hFFFF) halt_issued++;
         run_cyc[run_cnt % 256]  = cyc;
         run_pc[run_cnt % 256]   = pc;
         run_inst[run_cnt % 256] = instruction;
         run_cnt++;
         in_exec   = 1'b1;
         exec_inst = instruction;
      end else if (in_exec && instruction != exec_inst) begin
         stable_err++;
      end
      if (mem_rd_en) begin
         fetch_cnt++;
         if (prev_rd_en) rden_err++;
      end
      prev_rd_en = mem_rd_en;

      mem_rd_valid = 1'b0;
      if (mem_cnt > 0) begin
         mem_cnt--;
         if (mem_cnt == 0) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = mem[rd_addr];
            valid_cyc    = cyc;
         end
      end
      if (mem_rd_en) begin
         mem_cnt = mem_lat;
         rd_addr = mem_addr;
      end

      done      = 1'b0;
      core_stop = 1'b0;
      if (core_cnt > 0) begin
         core_cnt--;
         if (core_cnt == 0) begin
            done      = 1'b1;
            core_stop = stop_on_done;
            in_exec   = 1'b0;
         end
      end
      if (run) core_cnt = done_lat;
   end

   int n_checks = 0;
   int n_fail = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic check_reset_outputs(input string nm);
      check({nm, "_pc"}, pc, 0);
      check({nm, "_mem_addr"}, mem_addr, 0);
      check({nm, "_retired"}, retired, 0);
      check({nm, "_instruction"}, instruction, 0);
      check({nm, "_run"}, run, 0);
      check({nm, "_mem_rd_en"}, mem_rd_en, 0);
      check({nm, "_halted"}, halted, 0);
      check({nm, "_busy"}, busy, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 reset = 1'b0;
      start   = 1'b0;
      tb_stop = 1'b0;
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic pulse_start(output int sc);
      @(negedge clk);
      start = 1'b1;
      sc    = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_halt(input int budget, input string nm);
      int k = 0;
      while (!halted && k < budget) begin
         @(negedge clk);
         k++;
      end
      check({nm, "_reached_halt"}, halted, 1);
   endtask

   task automatic load_mem(input logic [15:0] w0, w1, w2, w3);
      mem[0] = w0;
      mem[1] = w1;
      mem[2] = w2;
      mem[3] = w3;
   endtask

   typedef struct {
      string         name;
      int            mem_lat;
      int            done_lat;
      logic [15:0]   w0, w1, w2, w3;
      int            exp_runs;
      logic [AW-1:0] exp_pc;
      logic [15:0]   exp_inst;
      int            exp_start_lat;
   } vec_t;

   vec_t vecs [5];

   initial begin
      int sc, base, fb, nr;
      bit found;

      vecs[0] = '{"prog_basic", 1, 3, 16'h1234, 16'h5678, 16'hFFFF, 16'h0000, 2, 2'd2, 16'h5678, 4};
      vecs[1] = '{"slow_mem",   5, 3, 16'h1234, 16'h5678, 16'hFFFF, 16'h0000, 2, 2'd2, 16'h5678, 8};
      vecs[2] = '{"halt_first", 1, 1, 16'hFFFF, 16'h1111, 16'h2222, 16'h3333, 0, 2'd0, 16'h0000, 0};
      vecs[3] = '{"three_inst", 2, 1, 16'h0001, 16'h0002, 16'h0003, 16'hFFFF, 3, 2'd3, 16'h0003, 5};
      vecs[4] = '{"one_inst",   1, 2, 16'h00AB, 16'hFFFF, 16'h0000, 16'h0000, 1, 2'd1, 16'h00AB, 4};

      // Asynchronous reset asserted between clock edges.
      #12 reset = 1'b0;
      #1 check_reset_outputs("async_reset");
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      @(negedge clk);
      check_reset_outputs("after_release");

      for (int i = 0; i < 5; i++) begin
         do_reset();
         load_mem(vecs[i].w0, vecs[i].w1, vecs[i].w2, vecs[i].w3);
         mem_lat      = vecs[i].mem_lat;
         done_lat     = vecs[i].done_lat;
         stop_on_done = 1'b0;
         base         = run_cnt;
         fb           = fetch_cnt;
         pulse_start(sc);
         wait_halt(300, vecs[i].name);
         check({vecs[i].name, "_pc"}, pc, vecs[i].exp_pc);
         check({vecs[i].name, "_retired"}, retired, vecs[i].exp_runs);
         check({vecs[i].name, "_instruction"}, instruction, vecs[i].exp_inst);
         check({vecs[i].name, "_runs"}, run_cnt - base, vecs[i].exp_runs);
         check({vecs[i].name, "_fetches"}, fetch_cnt - fb, vecs[i].exp_runs + 1);
         check({vecs[i].name, "_busy"}, busy, 0);
         if (vecs[i].exp_runs > 0) begin
            check({vecs[i].name, "_start_to_run"}, run_cyc[base % 256] - sc + 1, vecs[i].exp_start_lat);
            check({vecs[i].name, "_first_inst"}, run_inst[base % 256], vecs[i].w0);
         end
      end

      // stop coincident with done on the first instruction.
      do_reset();
      load_mem(16'h1234, 16'h5678, 16'hFFFF, 16'h0000);
      mem_lat      = 1;
      done_lat     = 3;
      stop_on_done = 1'b1;
      fb           = fetch_cnt;
      pulse_start(sc);
      wait_halt(100, "stop_done");
      repeat (5) @(negedge clk);
      check("stop_done_pc", pc, 1);
      check("stop_done_retired", retired, 1);
      check("stop_done_halted", halted, 1);
      check("stop_done_fetches", fetch_cnt - fb, 1);
      stop_on_done = 1'b0;

      // Reset during EXEC at pc=3 with the core's done landing after release.
      do_reset();
      load_mem(16'h0001, 16'h0001, 16'h0001, 16'h0001);
      mem_lat  = 1;
      done_lat = 4;
      pulse_start(sc);
      found = 1'b0;
      for (int k = 0; k < 300 && !found; k++) begin
         @(negedge clk);
         if (run && pc == 2'd3) found = 1'b1;
      end
      check("exec_pc3_found", found, 1);
      @(negedge clk);
      #2 reset = 1'b0;
      #1 check("midrun_reset_async_busy", busy, 0);
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      repeat (4) @(negedge clk);
      check_reset_outputs("stray_done");

      // PC wrap with a core that completes every instruction.
      do_reset();
      load_mem(16'h0001, 16'h0001, 16'h0001, 16'h0001);
      mem_lat  = 1;
      done_lat = 1;
      base     = run_cnt;
      pulse_start(sc);
      for (int k = 0; k < 200 && (run_cnt - base) < 6; k++) @(negedge clk);
      for (int k = 0; k < 6; k++) check($sformatf("wrap_pc_seq%0d", k), run_pc[(base + k) % 256], k % 4);
      check("wrap_not_halted", halted, 0);
      @(negedge clk);
      tb_stop = 1'b1;
      @(negedge clk);
      tb_stop = 1'b0;
      wait_halt(100, "wrap_stop");
      nr = run_cnt - base;
      check("wrap_stop_retired", retired, nr);
      check("wrap_stop_pc", pc, nr % 4);

      // Saturation of retired and restart from HALTED.
      force dut.retired_cnt = 16'hFFFE;
      @(negedge clk);
      release dut.retired_cnt;
      @(negedge clk);
      check("sat_preload", retired, 16'hFFFE);
      load_mem(16'h0001, 16'h0002, 16'hFFFF, 16'h0001);
      pulse_start(sc);
      check("restart_pc", pc, 0);
      wait_halt(100, "sat_run1");
      check("sat_retired", retired, 16'hFFFF);
      check("sat_pc", pc, 2);
      pulse_start(sc);
      check("restart2_pc", pc, 0);
      check("restart2_retired_kept", retired, 16'hFFFF);
      wait_halt(100, "sat_run2");
      check("sat_no_wrap", retired, 16'hFFFF);

      check("run_one_after_valid", lat_err, 0);
      check("inst_stable_run_to_done", stable_err, 0);
      check("rd_en_single_cycle", rden_err, 0);
      check("halt_word_never_issued", halt_issued, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
